router_reg: RTL and testbench
=============================

// Module: router_reg
// PURPOSE
//  Datapath register block of the 1x3 packet router; the router FSM drives its state strobes.
//  Latches the header byte and forwards header, payload and parity bytes to the FIFO input (dout).
//  Holds back a byte that arrives while the FIFO is full, and replays it in the laf state.
//  Computes running XOR parity over header+payload, compares it with the packet's parity byte, raises err.
// PARAMETERS
//  DATA_W  8  byte width (only 8 is supported; header = {len[5:0], addr[1:0]})
// PORTS
//  clock          in   1  single clock, all state updates on posedge
//  resetn         in   1  asynchronous, active-low reset
//  pkt_valid      in   1  source drives a valid header/payload byte; falls with the parity byte
//  fifo_full      in   1  selected destination FIFO is full
//  rst_int_reg    in   1  FSM request to clear low_pkt_valid
//  detect_add     in   1  FSM in DECODE_ADDRESS (header on data_in)
//  ld_state       in   1  FSM in LOAD_DATA
//  laf_state      in   1  FSM in LOAD_AFTER_FULL
//  full_state     in   1  FSM in FIFO_FULL_STATE
//  lfd_state      in   1  FSM in LOAD_FIRST_DATA (header write)
//  data_in        in   8  byte stream from source
//  parity_done    out  1  parity byte has been loaded
//  low_pkt_valid  out  1  pkt_valid fell during LOAD_DATA
//  err            out  1  parity mismatch for the current packet
//  dout           out  8  byte to destination FIFO
// BEHAVIOUR
//  Reset (resetn=0, async): dout, parity_done, low_pkt_valid, err and all internal regs -> 0.
//  Internal regs: hdr_byte, full_byte, int_parity, pkt_parity (8 b each).
//  hdr_byte: detect_add & pkt_valid & data_in[1:0]!=2'b11 -> data_in. Address 3 is invalid; hdr_byte holds.
//  dout, priority order; else hold:
//   1) lfd_state -> hdr_byte
//   2) ld_state & !fifo_full -> data_in
//   3) ld_state & fifo_full -> full_byte<=data_in; dout holds
//   4) laf_state -> full_byte
//  int_parity, priority order; else hold:
//   detect_add -> 0
//   lfd_state -> int_parity ^ hdr_byte
//   ld_state & pkt_valid & !full_state -> int_parity ^ data_in
//  pkt_parity: ld_state & !pkt_valid -> data_in (the parity byte).
//  parity_done, priority order:
//   detect_add -> 0
//   (ld_state & !fifo_full & !pkt_valid) | (laf_state & low_pkt_valid & !parity_done) -> 1
//   else hold
//  low_pkt_valid, priority order: rst_int_reg -> 0; ld_state & !pkt_valid -> 1; else hold.
//  err, priority order:
//   detect_add -> 0
//   parity_done -> (int_parity != pkt_parity)
//   else hold
//   err is valid 1 cycle after parity_done rises and stays stable until the next detect_add.
//  Latency: header on dout 1 cycle after lfd posedge; payload bytes appear 1 cycle after their ld posedge.
//  Simultaneous strobes: the FSM guarantees they are one-hot; if several are high, the priority order applies.
//  Reset mid-packet: everything clears immediately; the next packet restarts from detect_add.
// STRUCTURE
//  Shared package router_pkg: DATA_W=8, ADDR_INVALID=2'b11, header field slices (LEN=[7:2], ADDR=[1:0]).
//  One natural sub-module: router_parity_chk (int_parity, pkt_parity, parity_done, err); the rest stays inline.
// TESTING
//  1 Reset: resetn=0 mid-operation -> all outputs 0 asynchronously, before the next clock edge.
//  2 Good pkt: header 0x3A (len 14, addr 2), 14 random payload bytes, correct XOR parity byte
//    -> dout = 0x3A then each payload byte then parity; parity_done=1; low_pkt_valid=1; err=0.
//  3 Bad pkt: same sequence with ~parity as the last byte -> parity_done=1 and err=1 one cycle later.
//  4 FIFO full: fifo_full=1 during an ld byte
//    -> dout holds, byte goes to full_byte; in laf_state dout = that byte.
//    With low_pkt_valid=1 in laf, parity_done sets.
//  5 Invalid address: detect_add with header 0x3B (addr 3) -> hdr_byte unchanged.
//    A following lfd outputs the previous header.
//  6 Clears: rst_int_reg=1 -> low_pkt_valid=0; a new detect_add -> parity_done=0, err=0, int_parity=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and header field helpers for the 1x3 packet router datapath.
// Header byte layout: {len[5:0], addr[1:0]}; address 3 does not select any FIFO.
package router_pkg;

    localparam int DATA_W = 8;

    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 1;
    localparam int LEN_LSB  = 2;
    localparam int LEN_MSB  = 7;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef logic [DATA_W-1:0] byte_t;

    function automatic logic [ADDR_MSB-ADDR_LSB:0] hdr_addr(input byte_t hdr);
        return hdr[ADDR_MSB:ADDR_LSB];
    endfunction

    function automatic logic [LEN_MSB-LEN_LSB:0] hdr_len(input byte_t hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity over header+payload, captures the packet parity byte, flags mismatch.
// Latency: parity_done 1 cycle after the parity byte is accepted; err 1 cycle after parity_done.
// Backpressure: a parity byte held back by a full FIFO completes parity_done from the laf replay.
module router_parity_chk
    import router_pkg::*;
#(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              pkt_valid,
    input  logic              fifo_full,
    input  logic              low_pkt_valid,
    input  logic [DATA_W-1:0] hdr_byte,
    input  logic [DATA_W-1:0] data_in,
    output logic              parity_done,
    output logic              err
);

    logic [DATA_W-1:0] int_parity;
    logic [DATA_W-1:0] pkt_parity;

    // Only header and payload fold into the running parity; the parity byte itself is kept apart.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            int_parity <= '0;
        end else if (detect_add) begin
            int_parity <= '0;
        end else if (lfd_state) begin
            int_parity <= int_parity ^ hdr_byte;
        end else if (ld_state && pkt_valid && !full_state) begin
            int_parity <= int_parity ^ data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_parity <= '0;
        end else if (ld_state && !pkt_valid) begin
            pkt_parity <= data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            parity_done <= 1'b0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if ((ld_state && !fifo_full && !pkt_valid) ||
                     (laf_state && low_pkt_valid && !parity_done)) begin
            parity_done <= 1'b1;
        end
    end

    // Compare is registered off parity_done so both parity registers have settled.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (detect_add) begin
            err <= 1'b0;
        end else if (parity_done) begin
            err <= (int_parity != pkt_parity);
        end
    end

endmodule

// File: rtl/router_reg.sv
// Router datapath register: latches header, forwards header/payload/parity bytes to FIFO input.
// Latency: each byte on dout 1 cycle after its lfd/ld edge; a held byte replays in laf.
// Backpressure: a byte arriving with fifo_full is parked in full_byte and dout holds.
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic              fifo_full,
    input  logic              rst_int_reg,
    input  logic              detect_add,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] hdr_byte;
    logic [DATA_W-1:0] full_byte;

    // An invalid destination leaves the previous header in place.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hdr_byte <= '0;
        end else if (detect_add && pkt_valid && (hdr_addr(data_in) != ADDR_INVALID)) begin
            hdr_byte <= data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout      <= '0;
            full_byte <= '0;
        end else if (lfd_state) begin
            dout <= hdr_byte;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (ld_state && fifo_full) begin
            full_byte <= data_in;
        end else if (laf_state) begin
            dout <= full_byte;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid <= 1'b1;
        end
    end

    router_parity_chk #(
        .DATA_W (DATA_W)
    ) u_parity_chk (
        .clock         (clock),
        .resetn        (resetn),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .pkt_valid     (pkt_valid),
        .fifo_full     (fifo_full),
        .low_pkt_valid (low_pkt_valid),
        .hdr_byte      (hdr_byte),
        .data_in       (data_in),
        .parity_done   (parity_done),
        .err           (err)
    );

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: good/bad packets, FIFO-full replay, invalid address, clears, async reset.
module tb_router_reg;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid, fifo_full, rst_int_reg;
    logic       detect_add, ld_state, laf_state, full_state, lfd_state;
    logic [7:0] data_in;
    logic       parity_done, low_pkt_valid, err;
    logic [7:0] dout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] pl [14] = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67,
                            8'h78, 8'h89, 8'h9A, 8'hAB, 8'hBC, 8'hCD, 8'hDE};
    logic [7:0] par;

    router_reg dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .fifo_full     (fifo_full),
        .rst_int_reg   (rst_int_reg),
        .detect_add    (detect_add),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .lfd_state     (lfd_state),
        .data_in       (data_in),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err),
        .dout          (dout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobes: det lfd ld laf full, pkt_valid, fifo_full, rst_int_reg, byte.
    task automatic drive(input logic det, input logic lfd, input logic ld, input logic laf,
                         input logic fs, input logic pv, input logic ff, input logic ri,
                         input logic [7:0] d);
        detect_add  = det;
        lfd_state   = lfd;
        ld_state    = ld;
        laf_state   = laf;
        full_state  = fs;
        pkt_valid   = pv;
        fifo_full   = ff;
        rst_int_reg = ri;
        data_in     = d;
        tick();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        resetn = 1'b0;
        pkt_valid = 0; fifo_full = 0; rst_int_reg = 0;
        detect_add = 0; ld_state = 0; laf_state = 0; full_state = 0; lfd_state = 0;
        data_in = 8'h00;
        repeat (2) tick();
        chk("rst_dout", dout, 8'h00);
        chk("rst_pdone", parity_done, 8'h00);
        chk("rst_lowpv", low_pkt_valid, 8'h00);
        chk("rst_err", err, 8'h00);
        resetn = 1'b1;
        tick();

        // Good packet, header 0x3A
        par = 8'h3A;
        for (int i = 0; i < 14; i++) par = par ^ pl[i];
        drive(1, 0, 0, 0, 0, 1, 0, 0, 8'h3A);
        drive(0, 1, 0, 0, 0, 1, 0, 0, pl[0]);
        chk("good_hdr", dout, 8'h3A);
        for (int i = 0; i < 14; i++) begin
            drive(0, 0, 1, 0, 0, 1, 0, 0, pl[i]);
            chk($sformatf("good_pl%0d", i), dout, pl[i]);
        end
        chk("good_pdone_early", parity_done, 8'h00);
        drive(0, 0, 1, 0, 0, 0, 0, 0, par);
        chk("good_par_dout", dout, par);
        chk("good_pdone", parity_done, 8'h01);
        chk("good_lowpv", low_pkt_valid, 8'h01);
        idle();
        chk("good_err", err, 8'h00);

        // Bad packet: inverted parity byte
        drive(1, 0, 0, 0, 0, 1, 0, 0, 8'h3A);
        chk("bad_pdone_clr", parity_done, 8'h00);
        drive(0, 1, 0, 0, 0, 1, 0, 0, pl[0]);
        chk("bad_hdr", dout, 8'h3A);
        for (int i = 0; i < 14; i++) drive(0, 0, 1, 0, 0, 1, 0, 0, pl[i]);
        drive(0, 0, 1, 0, 0, 0, 0, 0, ~par);
        chk("bad_par_dout", dout, ~par);
        chk("bad_pdone", parity_done, 8'h01);
        chk("bad_err_early", err, 8'h00);
        idle();
        chk("bad_err", err, 8'h01);
        idle();
        chk("bad_err_hold", err, 8'h01);

        // rst_int_reg clears low_pkt_valid only
        drive(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
        chk("clr_lowpv", low_pkt_valid, 8'h00);
        chk("clr_err_hold", err, 8'h01);

        // Invalid address 3: header kept, detect clears parity_done/err
        drive(1, 0, 0, 0, 0, 1, 0, 0, 8'h3B);
        chk("inv_pdone", parity_done, 8'h00);
        chk("inv_err", err, 8'h00);
        drive(0, 1, 0, 0, 0, 1, 0, 0, 8'h55);
        chk("inv_hdr_kept", dout, 8'h3A);
        idle();

        // FIFO full on the parity byte: parked, then replayed in laf
        drive(1, 0, 0, 0, 0, 1, 0, 0, 8'h09);
        drive(0, 1, 0, 0, 0, 1, 0, 0, 8'h11);
        chk("ff_hdr", dout, 8'h09);
        drive(0, 0, 1, 0, 0, 1, 0, 0, 8'h11);
        chk("ff_pl0", dout, 8'h11);
        drive(0, 0, 1, 0, 0, 1, 0, 0, 8'h22);
        chk("ff_pl1", dout, 8'h22);
        drive(0, 0, 1, 0, 0, 0, 1, 0, 8'h3A);
        chk("ff_dout_hold", dout, 8'h22);
        chk("ff_pdone_0", parity_done, 8'h00);
        chk("ff_lowpv", low_pkt_valid, 8'h01);
        drive(0, 0, 0, 0, 1, 0, 1, 0, 8'h00);
        chk("ff_full_hold", dout, 8'h22);
        chk("ff_full_pdone", parity_done, 8'h00);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        chk("ff_laf_dout", dout, 8'h3A);
        chk("ff_laf_pdone", parity_done, 8'h01);
        idle();
        chk("ff_err", err, 8'h00);

        // Asynchronous reset between clock edges
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_dout", dout, 8'h00);
        chk("arst_pdone", parity_done, 8'h00);
        chk("arst_lowpv", low_pkt_valid, 8'h00);
        chk("arst_err", err, 8'h00);
        #1;
        resetn = 1'b1;
        tick();

        // Short packet after reset: header 0x06, payload 0xF0, parity 0xF6
        drive(1, 0, 0, 0, 0, 1, 0, 0, 8'h06);
        drive(0, 1, 0, 0, 0, 1, 0, 0, 8'hF0);
        chk("post_hdr", dout, 8'h06);
        drive(0, 0, 1, 0, 0, 1, 0, 0, 8'hF0);
        chk("post_pl", dout, 8'hF0);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 8'hF6);
        chk("post_par", dout, 8'hF6);
        chk("post_pdone", parity_done, 8'h01);
        idle();
        chk("post_err", err, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
